// File: rtl/pipe_stage_reg_if.sv
// Inter-stage pipeline bundle: one instruction's worth of boundary state.
// The producing side uses the master modport and the consuming side uses the slave modport.
interface pipe_stage_reg_if #(
   parameter int PAYLOAD_W = 64,
   parameter int TNEW_W    = 2
);
   logic                 valid;
   logic [31:0]          pc;
   logic                 bd;
   logic [PAYLOAD_W-1:0] payload;
   logic [4:0]           a3;
   logic                 regwrite;
   logic [TNEW_W-1:0]    tnew;
   logic                 check;

   modport master (
      output valid, pc, bd, payload, a3, regwrite, tnew, check
   );

   modport slave (
      input valid, pc, bd, payload, a3, regwrite, tnew, check
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline boundary register with hold, bubble insertion, Tnew ageing,
// $0-write suppression and a saturating count of cycles spent holding a real instruction.
module pipe_stage_reg #(
   parameter int PAYLOAD_W        = 64,
   parameter int TNEW_W           = 2,
   parameter bit DEC_ON_STALL     = 1'b0,
   parameter bit KEEP_PC_ON_FLUSH = 1'b1,
   parameter int CNT_W            = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              flush,
   input  logic              cnt_clr,
   pipe_stage_reg_if.slave   up,
   pipe_stage_reg_if.master  dn,
   output logic [CNT_W-1:0]  out_stall_cnt
);

   logic                 valid_r,    valid_s;
   logic [31:0]          pc_r,       pc_s;
   logic                 bd_r,       bd_s;
   logic [PAYLOAD_W-1:0] payload_r,  payload_s;
   logic [4:0]           a3_r,       a3_s;
   logic                 regwrite_r, regwrite_s;
   logic [TNEW_W-1:0]    tnew_r,     tnew_s;
   logic                 check_r,    check_s;
   logic [CNT_W-1:0]     cnt_r,      cnt_s;

   // Tnew ages by one per boundary crossed and never wraps below zero.
   function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] v);
      if (v == {TNEW_W{1'b0}}) begin
         sat_dec = {TNEW_W{1'b0}};
      end else begin
         sat_dec = v - TNEW_W'(1);
      end
   endfunction

   // Next-state selection: flush beats hold, hold beats load.
   always_comb begin
      valid_s    = valid_r;
      pc_s       = pc_r;
      bd_s       = bd_r;
      payload_s  = payload_r;
      a3_s       = a3_r;
      regwrite_s = regwrite_r;
      tnew_s     = tnew_r;
      check_s    = check_r;
      if (flush) begin
         valid_s    = 1'b0;
         payload_s  = {PAYLOAD_W{1'b0}};
         a3_s       = 5'd0;
         regwrite_s = 1'b0;
         tnew_s     = {TNEW_W{1'b0}};
         check_s    = 1'b0;
         // A bubble may keep the PC so a later exception still reports a sane EPC.
         if (KEEP_PC_ON_FLUSH) begin
            pc_s = up.pc;
            bd_s = up.bd;
         end else begin
            pc_s = 32'd0;
            bd_s = 1'b0;
         end
      end else if (!en) begin
         if (DEC_ON_STALL) begin
            tnew_s = sat_dec(tnew_r);
         end else begin
            tnew_s = tnew_r;
         end
      end else begin
         valid_s    = up.valid;
         pc_s       = up.pc;
         bd_s       = up.bd;
         payload_s  = up.payload;
         a3_s       = up.a3;
         regwrite_s = up.valid & up.regwrite & (up.a3 != 5'd0);
         tnew_s     = sat_dec(up.tnew);
         check_s    = up.valid & up.check;
      end
   end

   // Stall counter: clear wins, otherwise count held real instructions up to all-ones.
   always_comb begin
      if (cnt_clr) begin
         cnt_s = {CNT_W{1'b0}};
      end else if (!en && !flush && valid_r && (cnt_r != {CNT_W{1'b1}})) begin
         cnt_s = cnt_r + CNT_W'(1);
      end else begin
         cnt_s = cnt_r;
      end
   end

   // State registers; reset clears everything without waiting for a clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_r    <= 1'b0;
         pc_r       <= 32'd0;
         bd_r       <= 1'b0;
         payload_r  <= {PAYLOAD_W{1'b0}};
         a3_r       <= 5'd0;
         regwrite_r <= 1'b0;
         tnew_r     <= {TNEW_W{1'b0}};
         check_r    <= 1'b0;
         cnt_r      <= {CNT_W{1'b0}};
      end else begin
         valid_r    <= valid_s;
         pc_r       <= pc_s;
         bd_r       <= bd_s;
         payload_r  <= payload_s;
         a3_r       <= a3_s;
         regwrite_r <= regwrite_s;
         tnew_r     <= tnew_s;
         check_r    <= check_s;
         cnt_r      <= cnt_s;
      end
   end

   assign dn.valid      = valid_r;
   assign dn.pc         = pc_r;
   assign dn.bd         = bd_r;
   assign dn.payload    = payload_r;
   assign dn.a3         = a3_r;
   assign dn.regwrite   = regwrite_r;
   assign dn.tnew       = tnew_r;
   assign dn.check      = check_r;
   assign out_stall_cnt = cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: two instances (default parameters, and DEC_ON_STALL=1/KEEP_PC_ON_FLUSH=0/CNT_W=4)
// share one upstream bundle; a vector table plus hand sequences cover reset, counters and bubbles.
module tb_pipe_stage_reg;
   localparam int PW = 64;
   localparam int TW = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic en = 1'b0;
   logic flush = 1'b0;
   logic cnt_clr = 1'b0;
   logic [15:0] cnt_a;
   logic [3:0]  cnt_b;
   int errors = 0;
   int checks = 0;

   pipe_stage_reg_if #(.PAYLOAD_W(PW), .TNEW_W(TW)) up ();
   pipe_stage_reg_if #(.PAYLOAD_W(PW), .TNEW_W(TW)) dn_a ();
   pipe_stage_reg_if #(.PAYLOAD_W(PW), .TNEW_W(TW)) dn_b ();

   always #5 clk = ~clk;

   pipe_stage_reg #(.PAYLOAD_W(PW), .TNEW_W(TW), .DEC_ON_STALL(1'b0), .KEEP_PC_ON_FLUSH(1'b1), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .cnt_clr(cnt_clr),
      .up(up), .dn(dn_a), .out_stall_cnt(cnt_a)
   );

   pipe_stage_reg #(.PAYLOAD_W(PW), .TNEW_W(TW), .DEC_ON_STALL(1'b1), .KEEP_PC_ON_FLUSH(1'b0), .CNT_W(4)) dut_b (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .cnt_clr(cnt_clr),
      .up(up), .dn(dn_b), .out_stall_cnt(cnt_b)
   );

   typedef struct {
      logic en, fl, clr, v;
      logic [31:0] pc; logic bd; logic [63:0] pay; logic [4:0] a3; logic rw; logic [1:0] tn; logic ck;
      logic e_v; logic [31:0] e_pc; logic e_bd; logic [63:0] e_pay; logic [4:0] e_a3;
      logic e_rw; logic [1:0] e_tn; logic e_ck; logic [15:0] e_cnt;
      logic [31:0] b_pc; logic b_bd; logic [1:0] b_tn; logic [3:0] b_cnt;
   } vec_t;

   vec_t vecs [11];

   function automatic vec_t mk(
      input logic en_i, input logic fl, input logic clr, input logic v,
      input logic [31:0] pc, input logic bd, input logic [63:0] pay, input logic [4:0] a3,
      input logic rw, input logic [1:0] tn, input logic ck,
      input logic e_v, input logic [31:0] e_pc, input logic e_bd, input logic [63:0] e_pay,
      input logic [4:0] e_a3, input logic e_rw, input logic [1:0] e_tn, input logic e_ck,
      input logic [15:0] e_cnt,
      input logic [31:0] b_pc, input logic b_bd, input logic [1:0] b_tn, input logic [3:0] b_cnt);
      vec_t r;
      r.en = en_i; r.fl = fl; r.clr = clr; r.v = v; r.pc = pc; r.bd = bd; r.pay = pay;
      r.a3 = a3; r.rw = rw; r.tn = tn; r.ck = ck;
      r.e_v = e_v; r.e_pc = e_pc; r.e_bd = e_bd; r.e_pay = e_pay; r.e_a3 = e_a3;
      r.e_rw = e_rw; r.e_tn = e_tn; r.e_ck = e_ck; r.e_cnt = e_cnt;
      r.b_pc = b_pc; r.b_bd = b_bd; r.b_tn = b_tn; r.b_cnt = b_cnt;
      return r;
   endfunction

   function automatic logic [127:0] pk(
      input logic v, input logic [31:0] pc, input logic bd, input logic [63:0] pay,
      input logic [4:0] a3, input logic rw, input logic [1:0] tn, input logic ck, input logic [15:0] cnt);
      return {5'd0, v, pc, bd, pay, a3, rw, tn, ck, cnt};
   endfunction

   function automatic logic [127:0] act_a();
      return pk(dn_a.valid, dn_a.pc, dn_a.bd, dn_a.payload, dn_a.a3, dn_a.regwrite, dn_a.tnew, dn_a.check, cnt_a);
   endfunction

   function automatic logic [127:0] act_b();
      return pk(dn_b.valid, dn_b.pc, dn_b.bd, dn_b.payload, dn_b.a3, dn_b.regwrite, dn_b.tnew, dn_b.check,
                {12'd0, cnt_b});
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic en_i, input logic fl, input logic clr, input logic v,
                        input logic [31:0] pc, input logic bd, input logic [63:0] pay,
                        input logic [4:0] a3, input logic rw, input logic [1:0] tn, input logic ck);
      en = en_i; flush = fl; cnt_clr = clr;
      up.valid = v; up.pc = pc; up.bd = bd; up.payload = pay;
      up.a3 = a3; up.regwrite = rw; up.tnew = tn; up.check = ck;
   endtask

   initial begin
      vecs[0]  = mk(1'b1,1'b0,1'b0, 1'b1,32'h3000,1'b0,64'h1111,5'd5,1'b1,2'd2,1'b1,
                    1'b1,32'h3000,1'b0,64'h1111,5'd5,1'b1,2'd1,1'b1,16'd0, 32'h3000,1'b0,2'd1,4'd0);
      vecs[1]  = mk(1'b1,1'b0,1'b0, 1'b1,32'h3004,1'b0,64'h2222,5'd0,1'b1,2'd0,1'b0,
                    1'b1,32'h3004,1'b0,64'h2222,5'd0,1'b0,2'd0,1'b0,16'd0, 32'h3004,1'b0,2'd0,4'd0);
      vecs[2]  = mk(1'b1,1'b0,1'b0, 1'b1,32'h3010,1'b0,64'h3333,5'd9,1'b1,2'd3,1'b1,
                    1'b1,32'h3010,1'b0,64'h3333,5'd9,1'b1,2'd2,1'b1,16'd0, 32'h3010,1'b0,2'd2,4'd0);
      vecs[3]  = mk(1'b0,1'b0,1'b0, 1'b1,32'hdead,1'b1,64'hbeef,5'd1,1'b1,2'd3,1'b0,
                    1'b1,32'h3010,1'b0,64'h3333,5'd9,1'b1,2'd2,1'b1,16'd1, 32'h3010,1'b0,2'd1,4'd1);
      vecs[4]  = mk(1'b0,1'b0,1'b0, 1'b1,32'hdead,1'b1,64'hbeef,5'd1,1'b1,2'd3,1'b0,
                    1'b1,32'h3010,1'b0,64'h3333,5'd9,1'b1,2'd2,1'b1,16'd2, 32'h3010,1'b0,2'd0,4'd2);
      vecs[5]  = mk(1'b0,1'b0,1'b0, 1'b1,32'hdead,1'b1,64'hbeef,5'd1,1'b1,2'd3,1'b0,
                    1'b1,32'h3010,1'b0,64'h3333,5'd9,1'b1,2'd2,1'b1,16'd3, 32'h3010,1'b0,2'd0,4'd3);
      vecs[6]  = mk(1'b0,1'b1,1'b0, 1'b1,32'h3008,1'b1,64'hffff,5'd4,1'b1,2'd3,1'b1,
                    1'b0,32'h3008,1'b1,64'h0,5'd0,1'b0,2'd0,1'b0,16'd3, 32'h0,1'b0,2'd0,4'd3);
      vecs[7]  = mk(1'b0,1'b0,1'b0, 1'b1,32'h4000,1'b0,64'h7777,5'd6,1'b1,2'd3,1'b1,
                    1'b0,32'h3008,1'b1,64'h0,5'd0,1'b0,2'd0,1'b0,16'd3, 32'h0,1'b0,2'd0,4'd3);
      vecs[8]  = mk(1'b1,1'b0,1'b0, 1'b0,32'h3020,1'b0,64'h5555,5'd7,1'b1,2'd2,1'b1,
                    1'b0,32'h3020,1'b0,64'h5555,5'd7,1'b0,2'd1,1'b0,16'd3, 32'h3020,1'b0,2'd1,4'd3);
      vecs[9]  = mk(1'b1,1'b0,1'b1, 1'b1,32'h3024,1'b0,64'h6666,5'd3,1'b1,2'd1,1'b0,
                    1'b1,32'h3024,1'b0,64'h6666,5'd3,1'b1,2'd0,1'b0,16'd0, 32'h3024,1'b0,2'd0,4'd0);
      vecs[10] = mk(1'b1,1'b1,1'b0, 1'b1,32'h3028,1'b0,64'h8888,5'd2,1'b1,2'd2,1'b1,
                    1'b0,32'h3028,1'b0,64'h0,5'd0,1'b0,2'd0,1'b0,16'd0, 32'h0,1'b0,2'd0,4'd0);

      drive(1'b0,1'b0,1'b0, 1'b0,32'h0,1'b0,64'h0,5'd0,1'b0,2'd0,1'b0);
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_a", act_a(), 128'd0);
      check("reset_b", act_b(), 128'd0);

      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].en, vecs[i].fl, vecs[i].clr, vecs[i].v, vecs[i].pc, vecs[i].bd,
               vecs[i].pay, vecs[i].a3, vecs[i].rw, vecs[i].tn, vecs[i].ck);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_a", i), act_a(),
               pk(vecs[i].e_v, vecs[i].e_pc, vecs[i].e_bd, vecs[i].e_pay, vecs[i].e_a3,
                  vecs[i].e_rw, vecs[i].e_tn, vecs[i].e_ck, vecs[i].e_cnt));
         check($sformatf("vec%0d_b", i), act_b(),
               pk(vecs[i].e_v, vecs[i].b_pc, vecs[i].b_bd, vecs[i].e_pay, vecs[i].e_a3,
                  vecs[i].e_rw, vecs[i].b_tn, vecs[i].e_ck, {12'd0, vecs[i].b_cnt}));
         @(negedge clk);
      end

      // Long hold of a valid instruction: 16-bit counter reaches 20, 4-bit one sticks at 15.
      drive(1'b1,1'b0,1'b0, 1'b1,32'h3100,1'b0,64'h9,5'd1,1'b1,2'd0,1'b0);
      @(negedge clk);
      en = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("sat_cnt_a", {112'd0, cnt_a}, 128'd20);
      check("sat_cnt_b", {124'd0, cnt_b}, 128'd15);
      @(negedge clk);
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      check("clr_cnt_a", {112'd0, cnt_a}, 128'd0);
      check("clr_cnt_b", {124'd0, cnt_b}, 128'd0);
      @(negedge clk);
      cnt_clr = 1'b0;
      @(posedge clk);
      #1;
      check("recount_a", {112'd0, cnt_a}, 128'd1);
      check("recount_b", {124'd0, cnt_b}, 128'd1);

      // Asynchronous reset in the middle of a stall clears outputs with no clock edge.
      #2 reset = 1'b0;
      #1;
      check("midreset_a", act_a(), 128'd0);
      check("midreset_b", act_b(), 128'd0);

      @(negedge clk);
      reset = 1'b1;
      drive(1'b1,1'b0,1'b0, 1'b1,32'h3200,1'b1,64'hab,5'd5,1'b1,2'd2,1'b1);
      @(posedge clk);
      #1;
      check("first_load_a", act_a(), pk(1'b1,32'h3200,1'b1,64'hab,5'd5,1'b1,2'd1,1'b1,16'd0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
